bias_add_19: RTL

- Downstream consumer of the layer-19 bias streamer.
- At frame start it loads one bias coefficient per output channel from the bias FIFO stream.
- It then adds the matching bias to each convolution accumulator word, rescales, saturates and optionally applies ReLU.
- Results go to the next layer's FIFO. Sits between the conv-19 MAC array output FIFO and the layer-20 input FIFO.

---
 rtl/bias_add_19.sv | 129 ++++++++++++
 1 files changed

// File: rtl/bias_add_19.sv
// Layer-19 bias adder: loads one bias per output channel at frame start, then adds,
// rescales, saturates and optionally rectifies each accumulator word on its way to layer 20.
module bias_add_19 #(
  parameter int unsigned N_CH       = 16,
  parameter int unsigned PIXELS     = 64,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned COEFF_W    = 16,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned BIAS_SHIFT = 0,
  parameter int unsigned OUT_SHIFT  = 8,
  parameter bit          RELU       = 1'b1
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [COEFF_W-1:0] bias_V_dout,
  input  logic               bias_V_empty_n,
  output logic               bias_V_read,
  input  logic [ACC_W-1:0]   acc_V_dout,
  input  logic               acc_V_empty_n,
  output logic               acc_V_read,
  output logic [OUT_W-1:0]   output_V_din,
  input  logic               output_V_full_n,
  output logic               output_V_write,
  output logic               frame_done
);

  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int unsigned SUM_W = ACC_W + COEFF_W + BIAS_SHIFT + 1;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {LOAD, RUN} state_t;

  state_t             state;
  logic [CH_W-1:0]    ch_cnt;
  logic [PIX_W-1:0]   pix_cnt;
  logic               out_valid;
  logic [COEFF_W-1:0] bias_mem [N_CH];

  logic               bias_pop_c;
  logic               accept_c;
  logic signed [ACC_W-1:0]   acc_s_c;
  logic signed [COEFF_W-1:0] bias_s_c;
  logic signed [SUM_W-1:0]   sum_c;
  logic signed [SUM_W-1:0]   shr_c;
  logic [OUT_W-1:0]          res_c;

  // FIFO strobes: loading never waits on the output side; running stalls only on a blocked held word
  assign bias_pop_c     = (state == LOAD) & bias_V_empty_n;
  assign accept_c       = (state == RUN) & acc_V_empty_n & (~out_valid | output_V_full_n);
  assign bias_V_read    = bias_pop_c;
  assign acc_V_read     = accept_c;
  assign output_V_write = out_valid;

  // Bias add, floor rescale, saturate, optional ReLU
  always_comb begin
    acc_s_c  = acc_V_dout;
    bias_s_c = bias_mem[ch_cnt];
    sum_c    = SUM_W'(acc_s_c) + (SUM_W'(bias_s_c) <<< BIAS_SHIFT);
    shr_c    = sum_c >>> OUT_SHIFT;
    res_c    = shr_c[OUT_W-1:0];
    if (RELU && shr_c[SUM_W-1]) begin
      res_c = '0;
    end else if (shr_c > SAT_MAX) begin
      res_c = SAT_MAX[OUT_W-1:0];
    end else if (shr_c < SAT_MIN) begin
      res_c = SAT_MIN[OUT_W-1:0];
    end
  end

  // Bias table has no reset; ch_cnt returning to 0 is what discards a partial load
  always_ff @(posedge ap_clk) begin
    if (!ap_rst && bias_pop_c) begin
      bias_mem[ch_cnt] <= bias_V_dout;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state        <= LOAD;
      ch_cnt       <= '0;
      pix_cnt      <= '0;
      out_valid    <= 1'b0;
      output_V_din <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_valid && output_V_full_n && !accept_c) begin
        out_valid <= 1'b0;
      end
      case (state)
        LOAD: begin
          if (bias_pop_c) begin
            if (ch_cnt == CH_LAST) begin
              ch_cnt <= '0;
              state  <= RUN;
            end else begin
              ch_cnt <= ch_cnt + CH_W'(1);
            end
          end
        end
        RUN: begin
          if (accept_c) begin
            output_V_din <= res_c;
            out_valid    <= 1'b1;
            if (ch_cnt == CH_LAST) begin
              ch_cnt <= '0;
              if (pix_cnt == PIX_LAST) begin
                pix_cnt    <= '0;
                frame_done <= 1'b1;
                state      <= LOAD;
              end else begin
                pix_cnt <= pix_cnt + PIX_W'(1);
              end
            end else begin
              ch_cnt <= ch_cnt + CH_W'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
